arcade_input_conditioner: RTL and testbench
===========================================

ARCADE_INPUT_CONDITIONER -- requirements
Module: arcade_input_conditioner

Interface
REQ-001 SHALL provide parameter CHANNELS, default 8: number of independent button channels, 1..32.
REQ-002 SHALL provide parameter DEBOUNCE_BITS, default 9: debounce counter width; settle time 2^DEBOUNCE_BITS clocks.
REQ-003 SHALL provide parameter PULSE_LEN, default 1024: one-shot output length in clocks, >=1.
REQ-004 SHALL provide parameter AUTOFIRE_PERIOD, default 4096: autofire repeat period in clocks, even, >=2.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port btn_i, input, CHANNELS bits: raw asynchronous buttons, active-high (pressed=1).
REQ-008 SHALL have port mode_i, input, 2*CHANNELS bits: per-channel mode, bits [2c+1:2c]; 00 level, 01 toggle, 10 one-shot, 11 autofire.
REQ-009 SHALL have port state_o, output, CHANNELS bits: debounced button level.
REQ-010 SHALL have port press_o, output, CHANNELS bits: one-clock strobe on debounced press.
REQ-011 SHALL have port out_o, output, CHANNELS bits: mode-processed output.

Function
REQ-012 Each btn_i bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per channel: when synced != state, the counter SHALL increment; when synced == state, it SHALL clear to 0.
REQ-014 When the counter equals 2^DEBOUNCE_BITS-1 and synced != state, state SHALL take synced and the counter SHALL clear; total latency from a clean btn_i edge to state_o change = 2 + 2^DEBOUNCE_BITS clocks.
REQ-015 A glitch shorter than the settle time SHALL produce no state_o change.
REQ-016 press_o SHALL be high exactly one clock: the first clock in which state_o reads 1 after reading 0.
REQ-017 Level mode SHALL drive out_o = state_o with no added latency.
REQ-018 Toggle mode SHALL invert out_o on the clock press_o is high and hold it otherwise.
REQ-019 One-shot mode SHALL drive out_o high for exactly PULSE_LEN clocks, starting the press_o clock; presses during an active pulse SHALL be ignored (non-retriggerable).
REQ-020 In autofire mode, a press SHALL zero a phase counter; while state_o=1, phase SHALL advance 0..AUTOFIRE_PERIOD-1 and wrap; out_o = 1 when phase < AUTOFIRE_PERIOD/2.
REQ-021 In autofire mode, out_o SHALL go 0 in the same clock state_o goes 0, and the phase SHALL hold at 0.
REQ-022 A change of a channel's mode_i bits, detected against a registered copy, SHALL clear that channel's out_o, toggle bit, pulse timer and phase on the next clock; state_o SHALL be unaffected.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-024 Counter widths SHALL be sized from the parameters so no counter wraps before its terminal value.

Reset
REQ-025 While rst_i=1, synchronizers, debounce counters, state_o, press_o, out_o, toggle bits, pulse timers, phase counters and the registered mode copy SHALL be 0.
REQ-026 Reset asserted mid-pulse, mid-debounce or mid-autofire SHALL abort the operation; after release, a held button SHALL be debounced afresh and SHALL produce press_o.
REQ-027 The clock after rst_i falls SHALL begin normal operation; no output SHALL change in that clock.

Verification (CHANNELS=4, DEBOUNCE_BITS=2, PULSE_LEN=5, AUTOFIRE_PERIOD=4)
REQ-028 Debounce: btn_i[0] 0->1 held, mode 00 -> state_o[0], out_o[0] rise 6 clocks later, press_o[0] high 1 clock; a 3-clock glitch -> no change.
REQ-029 Toggle: mode 01, three clean presses -> out_o[1] sequence 1,0,1, each change on the press_o clock.
REQ-030 One-shot: mode 10, press, second press 2 clocks after the first press_o -> out_o[2] high exactly 5 clocks, no extension.
REQ-031 Autofire: mode 11, hold 12 clocks after state_o rises -> out_o[3] pattern 1,1,0,0 repeating; release -> out_o[3]=0 with state_o fall.
REQ-032 Reset/mode: rst_i for 1 clock mid-pulse -> all outputs 0; with button held -> press_o again 6 clocks after release; mode change 01->00 with out_o[1]=1 -> out_o[1] cleared next clock, then follows state_o.

Source files
------------

// File: rtl/arcade_input_conditioner.sv
// Arcade button conditioner: per-channel 2-flop synchronizer, counter debounce,
// press strobe and level / toggle / one-shot / autofire output shaping.
module arcade_input_conditioner #(
   parameter int CHANNELS        = 8,
   parameter int DEBOUNCE_BITS   = 9,
   parameter int PULSE_LEN       = 1024,
   parameter int AUTOFIRE_PERIOD = 4096
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CHANNELS-1:0]   btn_i,
   input  logic [2*CHANNELS-1:0] mode_i,
   output logic [CHANNELS-1:0]   state_o,
   output logic [CHANNELS-1:0]   press_o,
   output logic [CHANNELS-1:0]   out_o
);

   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam int AW = $clog2(AUTOFIRE_PERIOD);

   localparam logic [DEBOUNCE_BITS-1:0] DB_ONE  = DEBOUNCE_BITS'(1);
   localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = {DEBOUNCE_BITS{1'b1}};
   localparam logic [PW-1:0]            PL_ONE  = PW'(1);
   localparam logic [PW-1:0]            PL_LAST = PW'(PULSE_LEN - 1);
   localparam logic [AW-1:0]            AF_ONE  = AW'(1);
   localparam logic [AW-1:0]            AF_LAST = AW'(AUTOFIRE_PERIOD - 1);
   localparam logic [AW-1:0]            AF_HALF = AW'(AUTOFIRE_PERIOD / 2);

   localparam logic [1:0] MODE_LEVEL   = 2'b00;
   localparam logic [1:0] MODE_TOGGLE  = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
   localparam logic [1:0] MODE_AUTO    = 2'b11;

   logic [CHANNELS-1:0]      sync1_q, sync1_d;
   logic [CHANNELS-1:0]      sync2_q, sync2_d;
   logic [CHANNELS-1:0]      state_q, state_d;
   logic [CHANNELS-1:0]      press_q, press_d;
   logic [CHANNELS-1:0]      out_q,   out_d;
   logic [CHANNELS-1:0]      tog_q,   tog_d;
   logic [2*CHANNELS-1:0]    mode_q,  mode_d;
   logic [DEBOUNCE_BITS-1:0] cnt_q   [CHANNELS];
   logic [DEBOUNCE_BITS-1:0] cnt_d   [CHANNELS];
   logic [PW-1:0]            pulse_q [CHANNELS];
   logic [PW-1:0]            pulse_d [CHANNELS];
   logic [AW-1:0]            phase_q [CHANNELS];
   logic [AW-1:0]            phase_d [CHANNELS];

   assign state_o = state_q;
   assign press_o = press_q;
   assign out_o   = out_q;

   // Next-state for every channel; outputs are computed from next-state so the
   // registered out_o lines up with state_o/press_o in the same clock.
   always_comb begin
      sync1_d = btn_i;
      sync2_d = sync1_q;
      mode_d  = mode_i;
      state_d = state_q;
      press_d = '0;
      out_d   = '0;
      tog_d   = tog_q;
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c]   = '0;
         pulse_d[c] = pulse_q[c];
         phase_d[c] = phase_q[c];

         if (sync2_q[c] != state_q[c]) begin
            if (cnt_q[c] == DB_LAST) begin
               state_d[c] = sync2_q[c];
               cnt_d[c]   = '0;
            end else begin
               cnt_d[c]   = cnt_q[c] + DB_ONE;
            end
         end else begin
            cnt_d[c] = '0;
         end

         press_d[c] = state_d[c] & ~state_q[c];

         // A mode edit wipes all per-mode history; processing resumes under the new mode.
         if (mode_i[2*c +: 2] != mode_q[2*c +: 2]) begin
            tog_d[c]   = 1'b0;
            pulse_d[c] = '0;
            phase_d[c] = '0;
            out_d[c]   = 1'b0;
         end else begin
            case (mode_q[2*c +: 2])
               MODE_LEVEL: begin
                  out_d[c] = state_d[c];
               end
               MODE_TOGGLE: begin
                  tog_d[c] = tog_q[c] ^ press_d[c];
                  out_d[c] = tog_d[c];
               end
               MODE_ONESHOT: begin
                  if (pulse_q[c] != '0) begin
                     out_d[c]   = 1'b1;
                     pulse_d[c] = pulse_q[c] - PL_ONE;
                  end else if (press_d[c]) begin
                     out_d[c]   = 1'b1;
                     pulse_d[c] = PL_LAST;
                  end else begin
                     out_d[c]   = 1'b0;
                     pulse_d[c] = '0;
                  end
               end
               MODE_AUTO: begin
                  if (!state_d[c] || press_d[c]) begin
                     phase_d[c] = '0;
                  end else if (phase_q[c] == AF_LAST) begin
                     phase_d[c] = '0;
                  end else begin
                     phase_d[c] = phase_q[c] + AF_ONE;
                  end
                  out_d[c] = state_d[c] & (phase_d[c] < AF_HALF);
               end
               default: begin
                  out_d[c] = 1'b0;
               end
            endcase
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         state_q <= '0;
         press_q <= '0;
         out_q   <= '0;
         tog_q   <= '0;
         mode_q  <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]   <= '0;
            pulse_q[c] <= '0;
            phase_q[c] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         press_q <= press_d;
         out_q   <= out_d;
         tog_q   <= tog_d;
         mode_q  <= mode_d;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]   <= cnt_d[c];
            pulse_q[c] <= pulse_d[c];
            phase_q[c] <= phase_d[c];
         end
      end
   end

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Bench for arcade_input_conditioner: directed scenarios plus random traffic,
// checked against a per-channel behavioural model driven by elapsed time.
`timescale 1ns/1ps
module tb_arcade_input_conditioner;

   localparam int CH     = 4;
   localparam int DB     = 2;
   localparam int PL     = 5;
   localparam int AP     = 4;
   localparam int SETTLE = 1 << DB;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic [CH-1:0] btn  = '0;
   logic [2*CH-1:0] mode = '0;
   logic [CH-1:0] state_o, press_o, out_o;

   int n_checks = 0;
   int n_fail   = 0;
   int t        = 0;

   // Behavioural model state.
   logic [CH-1:0]   m_s1, m_s2, m_state, m_press, m_out;
   logic [2*CH-1:0] m_mode;
   int run_len   [CH];
   int tog_n     [CH];
   int pulse_end [CH];
   int af_start  [CH];

   arcade_input_conditioner #(
      .CHANNELS       (CH),
      .DEBOUNCE_BITS  (DB),
      .PULSE_LEN      (PL),
      .AUTOFIRE_PERIOD(AP)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (btn),
      .mode_i (mode),
      .state_o(state_o),
      .press_o(press_o),
      .out_o  (out_o)
   );

   always #5 clk = ~clk;

   // One clock of the reference: a level settles once it differs for SETTLE
   // consecutive synced samples; outputs derive from press counts and times.
   function automatic void model_step();
      logic       prev;
      logic [1:0] md;
      t++;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_out = '0; m_mode = '0;
         for (int c = 0; c < CH; c++) begin
            run_len[c] = 0; tog_n[c] = 0; pulse_end[c] = t; af_start[c] = t;
         end
         return;
      end
      for (int c = 0; c < CH; c++) begin
         md   = m_mode[2*c +: 2];
         prev = m_state[c];
         if (m_s2[c] != m_state[c]) begin
            run_len[c]++;
            if (run_len[c] == SETTLE) begin
               m_state[c] = m_s2[c];
               run_len[c] = 0;
            end
         end else begin
            run_len[c] = 0;
         end
         m_press[c] = m_state[c] & ~prev;
         if (mode[2*c +: 2] != md) begin
            tog_n[c] = 0; pulse_end[c] = t; af_start[c] = t; m_out[c] = 1'b0;
         end else begin
            case (md)
               2'b00: m_out[c] = m_state[c];
               2'b01: begin
                  if (m_press[c]) tog_n[c]++;
                  m_out[c] = (tog_n[c] % 2 == 1);
               end
               2'b10: begin
                  if (m_press[c] && t >= pulse_end[c]) pulse_end[c] = t + PL;
                  m_out[c] = (t < pulse_end[c]);
               end
               default: begin
                  if (m_press[c]) af_start[c] = t;
                  m_out[c] = m_state[c] && (((t - af_start[c]) % AP) < AP / 2);
               end
            endcase
         end
      end
      m_s2   = m_s1;
      m_s1   = btn;
      m_mode = mode;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      btn  = 4'($urandom);
      mode = 8'($urandom);
      repeat (4) begin
         tick();
         n_checks++;
         if ({state_o, press_o, out_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b/%b/%b, expected all 0", state_o, press_o, out_o);
         end
      end
      btn = '0;
      rst = 1'b0;
      tick();
      n_checks++;
      if ({state_o, press_o, out_o} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_first_clock: got %b/%b/%b, expected all 0", state_o, press_o, out_o);
      end
      repeat (8) begin
         tick();
         n_checks++;
         if ({state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
            n_fail++;
            $display("FAIL reset_drain t=%0d: got %b/%b/%b, expected %b/%b/%b",
                     t, state_o, press_o, out_o, m_state, m_press, m_out);
         end
      end
   endtask

   task automatic test_debounce();
      int lat;
      logic moved;
      mode = 8'b11_10_01_00;
      repeat (3) tick();
      btn[0] = 1'b1;
      lat = 0;
      while (state_o[0] !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== 2 + SETTLE) begin
         n_fail++;
         $display("FAIL debounce_latency: got %0d clocks, expected %0d", lat, 2 + SETTLE);
      end
      n_checks++;
      if (press_o[0] !== 1'b1 || out_o[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL debounce_rise: got press=%b out=%b, expected 1/1", press_o[0], out_o[0]);
      end
      tick();
      n_checks++;
      if (press_o[0] !== 1'b0 || state_o[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL press_one_clock: got press=%b state=%b, expected 0/1", press_o[0], state_o[0]);
      end
      btn[0] = 1'b0;
      repeat (10) tick();
      btn[0] = 1'b1;
      repeat (SETTLE - 1) tick();
      btn[0] = 1'b0;
      moved = 1'b0;
      repeat (12) begin
         tick();
         if (state_o[0] !== 1'b0 || press_o[0] !== 1'b0) moved = 1'b1;
         n_checks++;
         if ({state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
            n_fail++;
            $display("FAIL glitch_model t=%0d: got %b/%b/%b, expected %b/%b/%b",
                     t, state_o, press_o, out_o, m_state, m_press, m_out);
         end
      end
      n_checks++;
      if (moved !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_filter: got state/press activity, expected none");
      end
   endtask

   task automatic test_toggle();
      int   w;
      logic prev_out;
      for (int p = 0; p < 3; p++) begin
         btn[1]   = 1'b1;
         prev_out = out_o[1];
         w = 0;
         while (press_o[1] !== 1'b1 && w < 20) begin
            tick();
            w++;
            n_checks++;
            if (press_o[1] !== 1'b1 && out_o[1] !== prev_out) begin
               n_fail++;
               $display("FAIL toggle_hold: got out=%b without press, expected %b", out_o[1], prev_out);
            end
         end
         n_checks++;
         if (out_o[1] !== ((p % 2) == 0)) begin
            n_fail++;
            $display("FAIL toggle_seq press %0d: got %b, expected %b", p, out_o[1], (p % 2) == 0);
         end
         btn[1] = 1'b0;
         repeat (10) begin
            tick();
            n_checks++;
            if ({state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
               n_fail++;
               $display("FAIL toggle_model t=%0d: got %b/%b/%b, expected %b/%b/%b",
                        t, state_o, press_o, out_o, m_state, m_press, m_out);
            end
         end
      end
   endtask

   task automatic test_oneshot();
      int w;
      int high;
      btn[2] = 1'b1;
      w = 0;
      while (press_o[2] !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      n_checks++;
      if (press_o[2] !== 1'b1 || out_o[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL oneshot_start: got press=%b out=%b, expected 1/1", press_o[2], out_o[2]);
      end
      high = 1;
      btn[2] = 1'b0;
      tick();
      if (out_o[2] === 1'b1) high++;
      btn[2] = 1'b1;
      repeat (14) begin
         tick();
         if (out_o[2] === 1'b1) high++;
         n_checks++;
         if ({state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
            n_fail++;
            $display("FAIL oneshot_model t=%0d: got %b/%b/%b, expected %b/%b/%b",
                     t, state_o, press_o, out_o, m_state, m_press, m_out);
         end
      end
      n_checks++;
      if (high !== PL) begin
         n_fail++;
         $display("FAIL oneshot_len: got %0d clocks high, expected %0d", high, PL);
      end
      btn[2] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_autofire();
      int   w;
      logic pat_ok;
      btn[3] = 1'b1;
      w = 0;
      while (state_o[3] !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      pat_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (out_o[3] !== ((i % AP) < AP / 2)) pat_ok = 1'b0;
         tick();
      end
      n_checks++;
      if (pat_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL autofire_pattern: got deviation from 1100 repeat, expected none");
      end
      btn[3] = 1'b0;
      w = 0;
      while (state_o[3] !== 1'b0 && w < 20) begin
         tick();
         w++;
         n_checks++;
         if ({state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
            n_fail++;
            $display("FAIL autofire_model t=%0d: got %b/%b/%b, expected %b/%b/%b",
                     t, state_o, press_o, out_o, m_state, m_press, m_out);
         end
      end
      n_checks++;
      if (state_o[3] !== 1'b0 || out_o[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL autofire_release: got state=%b out=%b, expected 0/0", state_o[3], out_o[3]);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int w;
      int lat;
      btn[2] = 1'b1;
      w = 0;
      while (press_o[2] !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({state_o, press_o, out_o} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_mid_pulse: got %b/%b/%b, expected all 0", state_o, press_o, out_o);
      end
      rst = 1'b0;
      lat = 0;
      while (press_o[2] !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== 2 + SETTLE) begin
         n_fail++;
         $display("FAIL reset_repress: got press after %0d clocks, expected %0d", lat, 2 + SETTLE);
      end
      btn[2] = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_mode_change();
      int w;
      btn[1] = 1'b1;
      w = 0;
      while (press_o[1] !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      n_checks++;
      if (out_o[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_pre: got out=%b, expected 1", out_o[1]);
      end
      tick();
      mode[3:2] = 2'b00;
      tick();
      n_checks++;
      if (out_o[1] !== 1'b0 || state_o[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_clear: got out=%b state=%b, expected 0/1", out_o[1], state_o[1]);
      end
      tick();
      n_checks++;
      if (out_o[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_follow: got out=%b, expected 1", out_o[1]);
      end
      btn[1] = 1'b0;
      repeat (10) begin
         tick();
         n_checks++;
         if (out_o[1] !== state_o[1] || {state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
            n_fail++;
            $display("FAIL mode_level t=%0d: got %b/%b/%b, expected %b/%b/%b",
                     t, state_o, press_o, out_o, m_state, m_press, m_out);
         end
      end
   endtask

   task automatic test_random();
      int k;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, CH - 1);
            btn[k] = ~btn[k];
         end
         if ($urandom_range(0, 299) == 0) begin
            k = $urandom_range(0, CH - 1);
            mode[2*k +: 2] = 2'($urandom);
         end
         rst = ($urandom_range(0, 999) == 0);
         tick();
         n_checks++;
         if ({state_o, press_o, out_o} !== {m_state, m_press, m_out}) begin
            n_fail++;
            $display("FAIL random t=%0d: got %b/%b/%b, expected %b/%b/%b",
                     t, state_o, press_o, out_o, m_state, m_press, m_out);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_toggle();
      test_oneshot();
      test_autofire();
      test_reset_mid_pulse();
      test_mode_change();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
